// File: rtl/next_state_sequencer.sv
// Microprogram sequencer: picks the next control-store address from the
// next-state field and the selected condition bit, and registers it every clock.
module next_state_sequencer #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned RESET_STATE = 0,
  parameter int unsigned FETCH_STATE = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cond,
  input  logic              inv,
  input  logic [2:0]        n,
  input  logic [ADDR_W-1:0] cr_addr,
  input  logic [ADDR_W-1:0] dec_addr,
  output logic [ADDR_W-1:0] state,
  output logic [ADDR_W-1:0] link,
  output logic              waiting
);

  typedef enum logic [2:0] {
    SEL_DISPATCH        = 3'b000,
    SEL_FETCH           = 3'b001,
    SEL_BRANCH          = 3'b010,
    SEL_NEXT            = 3'b011,
    SEL_WAIT            = 3'b100,
    SEL_BRANCH_DISPATCH = 3'b101,
    SEL_CALL            = 3'b110,
    SEL_RETURN          = 3'b111
  } sel_e;

  localparam logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(RESET_STATE);
  localparam logic [ADDR_W-1:0] FETCH_ADDR = ADDR_W'(FETCH_STATE);

  logic [ADDR_W-1:0] state_q, state_d;
  logic [ADDR_W-1:0] link_q,  link_d;
  logic              waiting_q, waiting_d;
  logic [ADDR_W-1:0] inc_c;
  logic              t_c;
  sel_e              sel_c;

  // Next-address selection; the incrementer wraps silently at the top of the store.
  always_comb begin
    t_c       = cond ^ inv;
    inc_c     = state_q + ADDR_W'(1);
    sel_c     = sel_e'(n);
    state_d   = state_q;
    link_d    = link_q;
    waiting_d = 1'b0;
    case (sel_c)
      SEL_DISPATCH:        state_d = dec_addr;
      SEL_FETCH:           state_d = FETCH_ADDR;
      SEL_BRANCH:          state_d = t_c ? cr_addr : inc_c;
      SEL_NEXT:            state_d = inc_c;
      SEL_WAIT: begin
        state_d   = t_c ? inc_c : state_q;
        waiting_d = ~t_c;
      end
      SEL_BRANCH_DISPATCH: state_d = t_c ? cr_addr : dec_addr;
      SEL_CALL: begin
        // Single-entry link: a nested call overwrites the previous return address.
        state_d = cr_addr;
        link_d  = inc_c;
      end
      SEL_RETURN:          state_d = link_q;
      default:             state_d = state_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= RESET_ADDR;
      link_q    <= RESET_ADDR;
      waiting_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      link_q    <= link_d;
      waiting_q <= waiting_d;
    end
  end

  assign state   = state_q;
  assign link    = link_q;
  assign waiting = waiting_q;

endmodule

// File: doc/next_state_sequencer.md
# next_state_sequencer

Microprogram sequencer for the control unit. It consumes the single condition bit selected by the condition multiplexer and the next-state field of the current microinstruction, and registers the next control-store address every clock. Its `state` output addresses the microstore ROM, whose control register drives the condition multiplexer select and this block's `n`, `inv` and `cr_addr` inputs.

## Interface
Parameters:
- `ADDR_W`, 8: microstore address width.
- `RESET_STATE`, 0: address loaded on reset.
- `FETCH_STATE`, 1: start address of the instruction-fetch microroutine.

Ports:
- `clk`, input, 1: single clock; all state changes on the rising edge.
- `reset`, input, 1: synchronous, active-high; takes priority over every other input.
- `cond`, input, 1: condition bit from the condition multiplexer.
- `inv`, input, 1: microinstruction invert bit; effective condition `t = cond ^ inv`.
- `n`, input, 3: next-state selector field of the microinstruction.
- `cr_addr`, input, ADDR_W: branch target field of the control register.
- `dec_addr`, input, ADDR_W: entry address from the instruction encoder.
- `state`, output, ADDR_W: registered current microstore address.
- `link`, output, ADDR_W: registered micro-return address.
- `waiting`, output, 1: registered; high while the sequencer holds in a wait state.

## Operation
- Incrementer value `inc = state + 1`, computed modulo 2^ADDR_W. `{1..1} + 1` wraps to 0 with no flag.
- Next-state selection is combinational from the current inputs and `state`. It is registered on the edge:
  - 000: `dec_addr`. This is the decode dispatch.
  - 001: `FETCH_STATE`.
  - 010: if `t` then `cr_addr`, else `inc`. This is a conditional branch.
  - 011: `inc`.
  - 100: if `t` then `inc`, else hold `state`. This is a wait, for example on memory-operation-complete.
  - 101: if `t` then `cr_addr`, else `dec_addr`.
  - 110: call. `state <= cr_addr` and `link <= inc`.
  - 111: return. `state <= link`.
- `link` is written only by code 110. Every other code leaves it unchanged.
- `waiting <= (n == 100) & ~t`. This means `waiting` is high during the cycle after a failed wait test.
- The link register is one entry deep. A second 110 before a 111 overwrites `link`, and the previous return address is lost. This is intended.
- Code 111 with `link` never written returns to `RESET_STATE`, because that is the reset value of `link`.
- `cr_addr` and `dec_addr` are used as-is. There is no range checking.

## Timing
- Reset values: `state = RESET_STATE`, `link = RESET_STATE`, `waiting = 0`. They are applied at the first rising edge with `reset = 1`, whatever `n` and `cond` are.
- Reset mid-routine: the pending branch, call or wait is discarded. The cycle after `reset` deasserts, the microstore reads `RESET_STATE`.
- Latency: exactly one cycle from the inputs to `state`. No combinational path from the inputs to any output.
- `cond` must be stable at setup before the edge. The condition multiplexer output is sampled on the same edge as `n`.
- Wait handshake:
  - `state` holds at address A for as many cycles as `t = 0` with `n = 100`.
  - On the first edge with `t = 1`, `state <= A + 1` and `waiting` falls on that same edge.
- Call followed immediately by return: call at A to T, then 111 at T, gives `state` sequence A, T, A+1. `link` is written on the call edge and read on the next edge with no bypass hazard.
- 110 and 111 are never simultaneous, because `n` is a single encoded field.

## Test plan
- Reset: drive `n = 011` and `reset = 1` for 2 cycles, then release. Check `state = 0`, `link = 0` and `waiting = 0` while in reset. After release, check that `state` steps 1, 2, 3.
- Conditional branch with invert: `state = 0x10`, `n = 010`, `cr_addr = 0x40`.
  - `cond = 1`, `inv = 0`: next `state = 0x40`.
  - Repeat from 0x10 with `cond = 1`, `inv = 1`: next `state = 0x11`.
- Wait handshake: `state = 0x20`, `n = 100`, `cond = 0` for 3 cycles, then `cond = 1`. Check `state` stays 0x20 with `waiting = 1` for those 3 cycles, then `state = 0x21` and `waiting = 0`.
- Call/return: at `state = 0x05`, `n = 110`, `cr_addr = 0x80`. Then at 0x80, `n = 111`. Check `state` sequence 0x05, 0x80, 0x06 and `link = 0x06`.
- Dispatch and wrap:
  - `n = 000`, `dec_addr = 0x33`: next `state = 0x33`.
  - `n = 101`, `t = 0`, `dec_addr = 0x44`: next `state = 0x44`.
  - `state = 0xFF`, `n = 011`: next `state = 0x00`.
- Reset during wait: hold `state = 0x20` in a wait, then assert `reset` for 1 cycle. Check `state = 0`, `waiting = 0`, `link = 0`. With `n = 001` after release, check next `state = 1`.
